// File: rtl/sap_ctrl_pkg.sv
// Shared constants for the SAP-1 control sequencer: control-bit positions,
// named control words, opcodes and the phase-state encoding.
package sap_ctrl_pkg;

    localparam int SAP_OPW = 4;
    localparam int SAP_CWW = 12;
    localparam int SAP_NT  = 6;

    // Control-word bit positions
    localparam int CP = 11;
    localparam int EP = 10;
    localparam int LM = 9;
    localparam int CE = 8;
    localparam int LI = 7;
    localparam int EI = 6;
    localparam int LA = 5;
    localparam int EA = 4;
    localparam int SU = 3;
    localparam int EU = 2;
    localparam int LB = 1;
    localparam int LO = 0;

    typedef logic [SAP_CWW-1:0] cw_t;

    localparam cw_t CW_NONE  = '0;
    localparam cw_t FETCH_T1 = cw_t'((1 << EP) | (1 << LM));             // 0x600
    localparam cw_t FETCH_T2 = cw_t'(1 << CP);                           // 0x800
    localparam cw_t FETCH_T3 = cw_t'((1 << CE) | (1 << LI));             // 0x180
    localparam cw_t MEM_T4   = cw_t'((1 << EI) | (1 << LM));             // 0x240
    localparam cw_t LDA_T5   = cw_t'((1 << CE) | (1 << LA));             // 0x120
    localparam cw_t ALU_T5   = cw_t'((1 << CE) | (1 << LB));             // 0x102
    localparam cw_t ADD_T6   = cw_t'((1 << LA) | (1 << EU));             // 0x024
    localparam cw_t SUB_T6   = cw_t'((1 << LA) | (1 << SU) | (1 << EU)); // 0x02C
    localparam cw_t OUT_T4   = cw_t'((1 << EA) | (1 << LO));             // 0x011

    localparam logic [SAP_OPW-1:0] OP_LDA = 4'h0;
    localparam logic [SAP_OPW-1:0] OP_ADD = 4'h1;
    localparam logic [SAP_OPW-1:0] OP_SUB = 4'h2;
    localparam logic [SAP_OPW-1:0] OP_OUT = 4'hE;
    localparam logic [SAP_OPW-1:0] OP_HLT = 4'hF;

    // Codes 8..15 are illegal and fall back to IDLE
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T1   = 4'd1,
        ST_T2   = 4'd2,
        ST_T3   = 4'd3,
        ST_T4   = 4'd4,
        ST_T5   = 4'd5,
        ST_T6   = 4'd6,
        ST_HALT = 4'd7
    } state_e;

endpackage

// File: rtl/sap_control_sequencer_if.sv
// Run/opcode inputs and control/status outputs of the sequencer.
// master = the top level driving run/opcode; slave = the sequencer.
interface sap_control_sequencer_if #(
    parameter int OPW = 4,
    parameter int CWW = 12,
    parameter int NT  = 6
);
    logic           run;
    logic [OPW-1:0] opcode;
    logic [CWW-1:0] ctrl_word;
    logic [NT-1:0]  t_state;
    logic           instr_done;
    logic           halted;

    modport master (output run, opcode, input ctrl_word, t_state, instr_done, halted);
    modport slave  (input run, opcode, output ctrl_word, t_state, instr_done, halted);
endinterface

// File: rtl/sap_ring_counter.sv
// T-state ring: IDLE -> T1..T6 ring, run-gated, with HLT diverting T4 to HALT.
module sap_ring_counter
    import sap_ctrl_pkg::*;
#(
    parameter int NT = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          run,
    input  logic          is_hlt,
    output state_e        state,
    output logic [NT-1:0] t_state
);

    state_e state_nx;

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    // Next state: advance only on run, HALT is sticky, illegal codes recover to IDLE
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (run) state_nx = ST_T1;
            ST_T1:   if (run) state_nx = ST_T2;
            ST_T2:   if (run) state_nx = ST_T3;
            ST_T3:   if (run) state_nx = ST_T4;
            ST_T4:   if (run) state_nx = is_hlt ? ST_HALT : ST_T5;
            ST_T5:   if (run) state_nx = ST_T6;
            ST_T6:   if (run) state_nx = ST_T1;
            ST_HALT: state_nx = ST_HALT;
            default: state_nx = ST_IDLE;
        endcase
    end

    // One-hot phase; bit i marks T(i+1), all zero outside the ring
    for (genvar i = 0; i < NT; i++) begin : g_tst
        assign t_state[i] = (state == 4'(i + 1));
    end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP-1 control sequencer: ring counter plus opcode/phase decode to the
// 12-bit control word. Stalling zeroes the word so nothing loads or counts.
module sap_control_sequencer
    import sap_ctrl_pkg::*;
#(
    parameter int OPW = 4,
    parameter int CWW = 12,
    parameter int NT  = 6
) (
    input  logic                    clk,
    input  logic                    reset_n,
    sap_control_sequencer_if.slave  bus
);

    state_e         state;
    logic [OPW-1:0] op;
    logic [CWW-1:0] cw;

    assign op = bus.opcode;

    sap_ring_counter #(.NT(NT)) u_ring (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (bus.run),
        .is_hlt  (op == OP_HLT),
        .state   (state),
        .t_state (bus.t_state)
    );

    // Decode phase + opcode; undefined opcodes and HLT execute as all-zero words
    always_comb begin
        cw = CW_NONE;
        if (bus.run) begin
            case (state)
                ST_T1: cw = FETCH_T1;
                ST_T2: cw = FETCH_T2;
                ST_T3: cw = FETCH_T3;
                ST_T4: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB: cw = MEM_T4;
                        OP_OUT:                 cw = OUT_T4;
                        default:                cw = CW_NONE;
                    endcase
                end
                ST_T5: begin
                    case (op)
                        OP_LDA:         cw = LDA_T5;
                        OP_ADD, OP_SUB: cw = ALU_T5;
                        default:        cw = CW_NONE;
                    endcase
                end
                ST_T6: begin
                    case (op)
                        OP_ADD:  cw = ADD_T6;
                        OP_SUB:  cw = SUB_T6;
                        default: cw = CW_NONE;
                    endcase
                end
                default: cw = CW_NONE;
            endcase
        end
    end

    assign bus.ctrl_word  = cw;
    assign bus.instr_done = (state == ST_T6) && bus.run;
    assign bus.halted     = (state == ST_HALT);

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed vector table for the SAP-1 sequencer plus hand-written reset sequences.
module tb_sap_control_sequencer;

    logic clk;
    logic reset_n;

    sap_control_sequencer_if #(.OPW(4), .CWW(12), .NT(6)) sif ();

    sap_control_sequencer #(.OPW(4), .CWW(12), .NT(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (sif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        run;
        logic [3:0]  op;
        logic [11:0] cw;
        logic [5:0]  t;
        logic        done;
        logic        halt;
    } vec_t;

    vec_t vq[$];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic chk_all(input string nm, input logic [11:0] cw, input logic [5:0] t,
                           input logic done, input logic halt);
        chk({nm, " ctrl_word"},  32'(sif.ctrl_word),  32'(cw));
        chk({nm, " t_state"},    32'(sif.t_state),    32'(t));
        chk({nm, " instr_done"}, 32'(sif.instr_done), 32'(done));
        chk({nm, " halted"},     32'(sif.halted),     32'(halt));
    endtask

    task automatic addv(input logic r, input logic [3:0] o, input logic [11:0] c,
                        input logic [5:0] t, input logic d, input logic h);
        vec_t v;
        v.run = r; v.op = o; v.cw = c; v.t = t; v.done = d; v.halt = h;
        vq.push_back(v);
    endtask

    // One uninterrupted instruction: fetch words are fixed, execute words given
    task automatic instr(input logic [3:0] o, input logic [11:0] c4,
                         input logic [11:0] c5, input logic [11:0] c6);
        addv(1, o, 12'h600, 6'b000001, 0, 0);
        addv(1, o, 12'h800, 6'b000010, 0, 0);
        addv(1, o, 12'h180, 6'b000100, 0, 0);
        addv(1, o, c4,      6'b001000, 0, 0);
        addv(1, o, c5,      6'b010000, 0, 0);
        addv(1, o, c6,      6'b100000, 1, 0);
    endtask

    initial begin
        reset_n    = 1'b0;
        sif.run    = 1'b0;
        sif.opcode = 4'h0;
        #3;
        chk_all("reset", 12'h000, 6'b0, 0, 0);

        // IDLE holds without run, then leaves on the first run edge
        addv(0, 4'h0, 12'h000, 6'b000000, 0, 0);
        addv(1, 4'h0, 12'h000, 6'b000000, 0, 0);
        instr(4'h0, 12'h240, 12'h120, 12'h000);   // LDA
        instr(4'h2, 12'h240, 12'h102, 12'h02C);   // SUB
        instr(4'h1, 12'h240, 12'h102, 12'h024);   // ADD
        instr(4'hE, 12'h011, 12'h000, 12'h000);   // OUT
        instr(4'h7, 12'h000, 12'h000, 12'h000);   // undefined -> NOP
        // LDA with a 3-cycle stall in T2 and a 1-cycle stall in T6
        addv(1, 4'h0, 12'h600, 6'b000001, 0, 0);
        for (int k = 0; k < 3; k++) addv(0, 4'h0, 12'h000, 6'b000010, 0, 0);
        addv(1, 4'h0, 12'h800, 6'b000010, 0, 0);
        addv(1, 4'h0, 12'h180, 6'b000100, 0, 0);
        addv(1, 4'h0, 12'h240, 6'b001000, 0, 0);
        addv(1, 4'h0, 12'h120, 6'b010000, 0, 0);
        addv(0, 4'h0, 12'h000, 6'b100000, 0, 0);
        addv(1, 4'h0, 12'h000, 6'b100000, 1, 0);
        // HLT: fetch normally, T4 silent, then HALT regardless of run
        addv(1, 4'hF, 12'h600, 6'b000001, 0, 0);
        addv(1, 4'hF, 12'h800, 6'b000010, 0, 0);
        addv(1, 4'hF, 12'h180, 6'b000100, 0, 0);
        addv(1, 4'hF, 12'h000, 6'b001000, 0, 0);
        for (int k = 0; k < 10; k++) addv(logic'(k % 2 == 0), 4'hF, 12'h000, 6'b000000, 0, 1);

        @(negedge clk);
        reset_n = 1'b1;
        foreach (vq[i]) begin
            sif.run    = vq[i].run;
            sif.opcode = vq[i].op;
            #1;
            chk_all($sformatf("v%0d", i), vq[i].cw, vq[i].t, vq[i].done, vq[i].halt);
            @(negedge clk);
        end

        // Only reset leaves HALT; it acts without a clock edge
        sif.run = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk_all("halt_reset", 12'h000, 6'b0, 0, 0);
        @(negedge clk);
        reset_n    = 1'b1;
        sif.run    = 1'b1;
        sif.opcode = 4'h1;
        @(negedge clk);
        #1 chk_all("post_halt_t1", 12'h600, 6'b000001, 0, 0);
        repeat (4) @(negedge clk);
        #1 chk_all("add_t5", 12'h102, 6'b010000, 0, 0);

        // Async reset between edges during T5 of ADD
        #2 reset_n = 1'b0;
        #1 chk_all("mid_t5_reset", 12'h000, 6'b0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk_all("idle_after_reset", 12'h000, 6'b0, 0, 0);
        @(negedge clk);
        #1 chk_all("restart_t1", 12'h600, 6'b000001, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
